// File: rtl/nock_execute.sv
// nock_execute: performs one Nock reduction step on a cell handed over by the
// traversal unit and writes the result back in place as a constant cell [1 result].
//
// Ports:
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_error                     traversal-unit error code, nonzero aborts at start
//   i_execute_start             level request / memory mux select from traversal unit
//   i_execute_address/tag/data  the cell to reduce (head = subject, tail = formula ptr)
//   i_mem_ready                 memory idle/done
//   o_mem_execute, o_mem_func   one-cycle request strobe, 00 read / 01 write
//   o_address, o_write_data     request address and write word, held until completion
//   i_free_addr                 unused
//   i_read_data                 memory read word, valid when i_mem_ready returns high
//   o_finished                  one-cycle completion pulse
//   o_execute_return_sys_func   1 continue, 0 halt, F execution error
//   o_execute_return_state      2 ascend on success, otherwise error code
module nock_execute #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [7:0]            i_error,
    input  logic                  i_execute_start,
    input  logic [ADDR_WIDTH-1:0] i_execute_address,
    input  logic [4:0]            i_execute_tag,
    input  logic [DATA_WIDTH-1:0] i_execute_data,
    input  logic                  i_mem_ready,
    output logic                  o_mem_execute,
    output logic [1:0]            o_mem_func,
    output logic [ADDR_WIDTH-1:0] o_address,
    input  logic [ADDR_WIDTH-1:0] i_free_addr,
    input  logic [DATA_WIDTH-1:0] i_read_data,
    output logic [DATA_WIDTH-1:0] o_write_data,
    output logic                  o_finished,
    output logic [3:0]            o_execute_return_sys_func,
    output logic [3:0]            o_execute_return_state
);
    typedef enum logic [3:0] {
        S_IDLE, S_RD_FORM, S_WT_FORM, S_DECODE, S_RD_ARG,
        S_WT_ARG, S_WRITE, S_WT_WRITE, S_DONE, S_WAIT_LOW
    } state_t;

    localparam logic [27:0] ATOM_MAX = '1;
    localparam logic [1:0]  M_INC = 2'd0, M_HEAD = 2'd1, M_TAIL = 2'd2;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_cell_addr;
    logic [ADDR_WIDTH-1:0] r_fptr;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic                  r_head_atom;
    logic [27:0]           r_subj;
    logic [27:0]           r_op;
    logic [27:0]           r_arg;
    logic                  r_op_atom;
    logic                  r_arg_atom;
    logic [27:0]           r_res;
    logic                  r_res_atom;
    logic [1:0]            r_mode;
    logic [3:0]            r_err;
    logic                  r_halt;
    logic                  r_seen_low;

    logic        w_mem_done;
    logic [27:0] w_rd_head;
    logic [27:0] w_rd_tail;
    logic        w_rd_hatom;
    logic        w_rd_tatom;
    logic        w_unused;

    // A request completes only after ready has been seen low, so the cycle the
    // strobe is still high (ready not yet dropped) is never taken as completion.
    assign w_mem_done = r_seen_low & i_mem_ready;
    assign w_rd_head  = i_read_data[55:28];
    assign w_rd_tail  = i_read_data[27:0];
    assign w_rd_hatom = i_read_data[60];
    assign w_rd_tatom = i_read_data[59];
    assign w_unused   = ^{i_free_addr, i_execute_tag[4:2], i_execute_data[DATA_WIDTH-1:56],
                          i_execute_data[27:ADDR_WIDTH], i_read_data[DATA_WIDTH-1:61],
                          i_read_data[58:56]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state                   <= S_IDLE;
            r_cell_addr               <= '0;
            r_fptr                    <= '0;
            r_ptr                     <= '0;
            r_head_atom               <= 1'b0;
            r_subj                    <= '0;
            r_op                      <= '0;
            r_arg                     <= '0;
            r_op_atom                 <= 1'b0;
            r_arg_atom                <= 1'b0;
            r_res                     <= '0;
            r_res_atom                <= 1'b0;
            r_mode                    <= M_INC;
            r_err                     <= '0;
            r_halt                    <= 1'b0;
            r_seen_low                <= 1'b0;
            o_mem_execute             <= 1'b0;
            o_mem_func                <= 2'b00;
            o_address                 <= '0;
            o_write_data              <= '0;
            o_finished                <= 1'b0;
            o_execute_return_sys_func <= '0;
            o_execute_return_state    <= '0;
        end else begin
            o_mem_execute <= 1'b0;
            o_finished    <= 1'b0;
            case (r_state)
                S_IDLE: if (i_execute_start) begin
                    r_cell_addr <= i_execute_address;
                    r_head_atom <= i_execute_tag[1];
                    r_subj      <= i_execute_data[55:28];
                    r_fptr      <= i_execute_data[ADDR_WIDTH-1:0];
                    r_err       <= '0;
                    r_halt      <= 1'b0;
                    r_seen_low  <= 1'b0;
                    if (i_error != 8'd0) begin
                        r_halt  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (i_execute_tag[0]) begin
                        r_err   <= 4'd1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_RD_FORM;
                    end
                end
                S_RD_FORM: if (i_mem_ready) begin
                    o_mem_execute <= 1'b1;
                    o_mem_func    <= 2'b00;
                    o_address     <= r_fptr;
                    r_state       <= S_WT_FORM;
                end
                S_WT_FORM: begin
                    if (!i_mem_ready) r_seen_low <= 1'b1;
                    if (w_mem_done) begin
                        r_seen_low <= 1'b0;
                        r_op       <= w_rd_head;
                        r_arg      <= w_rd_tail;
                        r_op_atom  <= w_rd_hatom;
                        r_arg_atom <= w_rd_tatom;
                        r_state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_state <= S_DONE;
                    if (!r_op_atom) begin
                        r_err <= 4'd2;
                    end else if (r_op == 28'd1) begin
                        r_res      <= r_arg;
                        r_res_atom <= r_arg_atom;
                        r_state    <= S_WRITE;
                    end else if (r_op == 28'd4) begin
                        if (!r_arg_atom) begin
                            r_mode  <= M_INC;
                            r_ptr   <= r_arg[ADDR_WIDTH-1:0];
                            r_state <= S_RD_ARG;
                        end else if (r_arg == ATOM_MAX) begin
                            r_err <= 4'd4;
                        end else begin
                            r_res      <= r_arg + 28'd1;
                            r_res_atom <= 1'b1;
                            r_state    <= S_WRITE;
                        end
                    end else if (r_op == 28'd0) begin
                        if (r_arg_atom && r_arg == 28'd1) begin
                            r_res      <= r_subj;
                            r_res_atom <= r_head_atom;
                            r_state    <= S_WRITE;
                        end else if (r_arg_atom && !r_head_atom && (r_arg == 28'd2 || r_arg == 28'd3)) begin
                            r_mode  <= (r_arg == 28'd2) ? M_HEAD : M_TAIL;
                            r_ptr   <= r_subj[ADDR_WIDTH-1:0];
                            r_state <= S_RD_ARG;
                        end else begin
                            r_err <= 4'd5;
                        end
                    end else begin
                        r_err <= 4'd3;
                    end
                end
                S_RD_ARG: if (i_mem_ready) begin
                    o_mem_execute <= 1'b1;
                    o_mem_func    <= 2'b00;
                    o_address     <= r_ptr;
                    r_state       <= S_WT_ARG;
                end
                S_WT_ARG: begin
                    if (!i_mem_ready) r_seen_low <= 1'b1;
                    if (w_mem_done) begin
                        r_seen_low <= 1'b0;
                        r_state    <= S_WRITE;
                        if (r_mode == M_HEAD) begin
                            r_res      <= w_rd_head;
                            r_res_atom <= w_rd_hatom;
                        end else if (r_mode == M_TAIL) begin
                            r_res      <= w_rd_tail;
                            r_res_atom <= w_rd_tatom;
                        end else if (!(w_rd_hatom && w_rd_tatom && w_rd_head == 28'd1)) begin
                            // increment of a pointer needs a constant cell [1 c]
                            r_err   <= 4'd5;
                            r_state <= S_DONE;
                        end else if (w_rd_tail == ATOM_MAX) begin
                            r_err   <= 4'd4;
                            r_state <= S_DONE;
                        end else begin
                            r_res      <= w_rd_tail + 28'd1;
                            r_res_atom <= 1'b1;
                        end
                    end
                end
                S_WRITE: if (i_mem_ready) begin
                    o_mem_execute <= 1'b1;
                    o_mem_func    <= 2'b01;
                    o_address     <= r_cell_addr;
                    // execute marker cleared, head atom 1, tail is the result
                    o_write_data  <= DATA_WIDTH'({4'b0001, r_res_atom, 3'b000, 28'd1, r_res});
                    r_state       <= S_WT_WRITE;
                end
                S_WT_WRITE: begin
                    if (!i_mem_ready) r_seen_low <= 1'b1;
                    if (w_mem_done) begin
                        r_seen_low <= 1'b0;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    o_finished                <= 1'b1;
                    o_execute_return_sys_func <= r_halt ? 4'h0 : (r_err != 4'd0) ? 4'hF : 4'h1;
                    o_execute_return_state    <= r_halt ? 4'h0 : (r_err != 4'd0) ? r_err : 4'h2;
                    r_state                   <= S_WAIT_LOW;
                end
                S_WAIT_LOW: if (!i_execute_start) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nock_execute.sv
// tb_nock_execute: scoreboard bench for nock_execute with a handshake memory model.
module tb_nock_execute;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  error;
    logic        start;
    logic [9:0]  ex_addr;
    logic [4:0]  ex_tag;
    logic [63:0] ex_data;
    logic        mem_ready;
    logic        mem_execute;
    logic [1:0]  mem_func;
    logic [9:0]  address;
    logic [63:0] read_data;
    logic [63:0] write_data;
    logic        finished;
    logic [3:0]  ret_func;
    logic [3:0]  ret_state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          kind;
        logic [9:0]  addr;
        logic [63:0] data;
    } exp_t;
    exp_t q[$];
    logic [63:0] mem [0:1023];

    localparam logic [27:0] AMAX = '1;

    nock_execute #(.ADDR_WIDTH(10), .DATA_WIDTH(64)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_error(error), .i_execute_start(start),
        .i_execute_address(ex_addr), .i_execute_tag(ex_tag), .i_execute_data(ex_data),
        .i_mem_ready(mem_ready), .o_mem_execute(mem_execute), .o_mem_func(mem_func),
        .o_address(address), .i_free_addr(10'd0), .i_read_data(read_data),
        .o_write_data(write_data), .o_finished(finished),
        .o_execute_return_sys_func(ret_func), .o_execute_return_state(ret_state)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mk(input logic [4:0] t, input logic [27:0] h, input logic [27:0] tl);
        return {t, 3'b000, h, tl};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // kind: 0 read, 1 write, 2 finished, 3 illegal func
    task automatic check_ev(input int kind, input logic [9:0] a, input logic [63:0] d);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event kind=%0d addr=%0d data=%h expected=none", kind, a, d);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.addr !== a || e.data !== d) begin
                errors++;
                $display("FAIL event actual kind=%0d addr=%0d data=%h expected kind=%0d addr=%0d data=%h",
                         kind, a, d, e.kind, e.addr, e.data);
            end
        end
    endtask

    task automatic exp_rd(input logic [9:0] a);
        q.push_back('{0, a, 64'd0});
    endtask
    task automatic exp_wr(input logic [9:0] a, input logic [63:0] d);
        q.push_back('{1, a, d});
    endtask
    task automatic exp_fin(input logic [3:0] f, input logic [3:0] s);
        q.push_back('{2, 10'd0, {56'd0, f, s}});
    endtask

    // memory model: takes a strobe while idle, drops ready, completes two cycles later
    initial begin
        logic [9:0]  a;
        logic [1:0]  f;
        logic [63:0] d;
        int          k;
        mem_ready = 1'b1;
        read_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_execute) begin
                a = address;
                f = mem_func;
                d = write_data;
                k = (f == 2'b00) ? 0 : (f == 2'b01) ? 1 : 3;
                check_ev(k, a, (k == 1) ? d : 64'd0);
                mem_ready = 1'b0;
                repeat (2) begin
                    @(posedge clk);
                    #1;
                    if (mem_execute) begin
                        checks++;
                        errors++;
                        $display("FAIL strobe_while_busy actual=1 expected=0");
                    end
                end
                if (f == 2'b01) mem[a] = d;
                else read_data = mem[a];
                mem_ready = 1'b1;
            end
        end
    end

    always @(negedge clk) if (finished) check_ev(2, 10'd0, {56'd0, ret_func, ret_state});

    task automatic run(input logic [9:0] a, input logic [4:0] t, input logic [27:0] h,
                       input logic [27:0] f, input logic [7:0] e, input bit drop);
        int n = 0;
        ex_addr = a;
        ex_tag  = t;
        ex_data = mk(t, h, f);
        error   = e;
        start   = 1'b1;
        if (drop) begin
            @(posedge clk);
            #1 start = 1'b0;
        end
        do begin
            @(negedge clk);
            n++;
        end while (!finished && n < 300);
        if (!finished) begin
            checks++;
            errors++;
            $display("FAIL finished_timeout actual=0 expected=1");
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        error = 8'd0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int pulses;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[100] = mk(5'b00011, 28'd1, 28'd42);
        mem[101] = mk(5'b00011, 28'd4, 28'd5);
        mem[102] = mk(5'b00010, 28'd4, 28'd200);
        mem[200] = mk(5'b00011, 28'd1, 28'd9);
        mem[103] = mk(5'b00011, 28'd4, AMAX);
        mem[104] = mk(5'b00011, 28'd9, 28'd0);
        mem[300] = mk(5'b00011, 28'd3, 28'd8);
        mem[105] = mk(5'b00011, 28'd0, 28'd3);
        mem[106] = mk(5'b00011, 28'd0, 28'd1);
        mem[107] = mk(5'b00001, 28'd400, 28'd5);
        mem[108] = mk(5'b00010, 28'd4, 28'd201);
        mem[201] = mk(5'b00011, 28'd2, 28'd9);
        mem[109] = mk(5'b00011, 28'd0, 28'd2);
        mem[110] = mk(5'b00011, 28'd0, 28'd2);
        mem[111] = mk(5'b00010, 28'd4, 28'd202);
        mem[202] = mk(5'b00011, 28'd1, 28'd20);
        rst_n = 1'b0; error = '0; start = 1'b0; ex_addr = '0; ex_tag = '0; ex_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_execute", 64'(mem_execute), 64'd0);
        chk("rst_finished", 64'(finished), 64'd0);
        chk("rst_ret", 64'({ret_func, ret_state}), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        exp_rd(100); exp_wr(10, mk(5'b00011, 28'd1, 28'd42)); exp_fin(4'h1, 4'h2);
        run(10, 5'b10010, 28'd7, 28'd100, 8'd0, 1'b0);

        exp_rd(101); exp_wr(11, mk(5'b00011, 28'd1, 28'd6)); exp_fin(4'h1, 4'h2);
        run(11, 5'b10010, 28'd7, 28'd101, 8'd0, 1'b1);

        exp_rd(102); exp_rd(200); exp_wr(12, mk(5'b00011, 28'd1, 28'd10)); exp_fin(4'h1, 4'h2);
        run(12, 5'b10010, 28'd7, 28'd102, 8'd0, 1'b0);

        exp_rd(103); exp_fin(4'hF, 4'h4);
        run(13, 5'b10010, 28'd7, 28'd103, 8'd0, 1'b0);

        exp_rd(104); exp_fin(4'hF, 4'h3);
        run(14, 5'b10010, 28'd7, 28'd104, 8'd0, 1'b0);

        exp_rd(105); exp_rd(300); exp_wr(15, mk(5'b00011, 28'd1, 28'd8)); exp_fin(4'h1, 4'h2);
        run(15, 5'b10000, 28'd300, 28'd105, 8'd0, 1'b0);

        exp_rd(106); exp_wr(16, mk(5'b00010, 28'd1, 28'd300)); exp_fin(4'h1, 4'h2);
        run(16, 5'b10000, 28'd300, 28'd106, 8'd0, 1'b0);

        exp_fin(4'h0, 4'h0);
        run(17, 5'b10010, 28'd7, 28'd100, 8'h01, 1'b0);

        exp_fin(4'hF, 4'h1);
        run(18, 5'b10011, 28'd7, 28'd100, 8'd0, 1'b0);

        exp_rd(107); exp_fin(4'hF, 4'h2);
        run(19, 5'b10010, 28'd7, 28'd107, 8'd0, 1'b0);

        exp_rd(108); exp_rd(201); exp_fin(4'hF, 4'h5);
        run(20, 5'b10010, 28'd7, 28'd108, 8'd0, 1'b0);

        exp_rd(109); exp_fin(4'hF, 4'h5);
        run(21, 5'b10010, 28'd7, 28'd109, 8'd0, 1'b0);

        exp_rd(110); exp_rd(300); exp_wr(22, mk(5'b00011, 28'd1, 28'd3)); exp_fin(4'h1, 4'h2);
        run(22, 5'b10000, 28'd300, 28'd110, 8'd0, 1'b0);

        // reset while the argument read is outstanding
        exp_rd(111); exp_rd(202);
        ex_addr = 23; ex_tag = 5'b10010; ex_data = mk(5'b10010, 28'd7, 28'd111); start = 1'b1;
        n = 0; pulses = 0;
        while (pulses < 2 && n < 300) begin
            @(negedge clk);
            n++;
            if (mem_execute) pulses++;
        end
        chk("second_read_issued", 64'(pulses), 64'd2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_mem_execute", 64'(mem_execute), 64'd0);
        chk("rst_mid_address", 64'(address), 64'd0);
        chk("rst_mid_func", 64'(mem_func), 64'd0);
        chk("rst_mid_write_data", write_data, 64'd0);
        chk("rst_mid_finished", 64'(finished), 64'd0);
        chk("rst_mid_ret", 64'({ret_func, ret_state}), 64'd0);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        exp_rd(100); exp_wr(24, mk(5'b00011, 28'd1, 28'd42)); exp_fin(4'h1, 4'h2);
        run(24, 5'b10010, 28'd7, 28'd100, 8'd0, 1'b0);

        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
